hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32: number of architectural registers tracked.
REQ-002 Parameter CNT_W, default 2: width of each in-flight write counter; saturation value is 2^CNT_W-1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 id_valid_inst  input  1  ID holds a valid decoded instruction.
REQ-006 id_ra_idx, id_rb_idx  input  5 each  source register indices.
REQ-007 id_uses_ra, id_uses_rb  input  1 each  instruction reads that source.
REQ-008 id_reg_wr  input  1  instruction writes rd.
REQ-009 id_dest_reg_idx  input  5  rd index.
REQ-010 id_halt  input  1  ID instruction is ebreak.
REQ-011 flush  input  1  taken branch/jump this cycle; kills the ID instruction.
REQ-012 wb_valid_inst, wb_reg_wr  input  1 each  WB retires a valid instruction that writes rd.
REQ-013 wb_dest_reg_idx  input  5  WB rd index.
REQ-014 stall  output  1  hold IF/ID this cycle.
REQ-015 issue  output  1  ID instruction advances to EX this cycle.
REQ-016 busy  output  1  at least one counter is non-zero.
REQ-017 halted  output  1  pipeline drained after ebreak.

Function
REQ-018 One counter per register 1..NUM_REGS-1; register 0 has no counter and never causes a hazard.
REQ-019 src_hazard = (id_uses_ra & ra!=0 & cnt[ra]!=0) | (id_uses_rb & rb!=0 & cnt[rb]!=0), using registered counter values only; a same-cycle writeback does not clear the hazard.
REQ-020 sat_hazard = id_reg_wr & rd!=0 & cnt[rd]==max.
REQ-021 stall = id_valid_inst & ~flush & (src_hazard | sat_hazard | state!=RUN); stall is combinational, zero-cycle latency.
REQ-022 issue = id_valid_inst & ~flush & ~stall.
REQ-023 On issue with id_reg_wr & rd!=0, cnt[rd] increments at the next edge.
REQ-024 On wb_valid_inst & wb_reg_wr & wb_idx!=0, cnt[wb_idx] decrements at the next edge; a decrement at 0 is ignored, with no underflow.
REQ-025 If the increment and decrement hit the same register in one cycle, the counter is unchanged.
REQ-026 flush suppresses issue and stall; it never alters counters.
REQ-027 FSM states: RUN, DRAIN, HALTED.
REQ-028 RUN -> DRAIN when issue & id_halt.
REQ-029 DRAIN -> HALTED when all counters are 0 and no decrement is pending that cycle.
REQ-030 HALTED is sticky until reset.
REQ-031 In DRAIN and HALTED, no new instruction issues; writebacks still decrement.
REQ-032 busy = OR of all counters (registered); halted = (state==HALTED).

Reset
REQ-033 When rst=0 at an edge: all counters are set to 0 and state is set to RUN.
REQ-034 Outputs after reset: busy=0, halted=0; stall and issue follow inputs per REQ-021/022.
REQ-035 Reset asserted mid-DRAIN or mid-HALTED returns to RUN with cleared counters on that edge; reset has priority over issue and writeback.

Structure
REQ-036 The shared package holds the FSM state enum (SB_RUN, SB_DRAIN, SB_HALTED), ZERO_REG, and the default widths.
REQ-037 One sub-module, sb_entry, implements a single saturating up/down counter with inc/dec inputs and a nonzero/full output, instantiated NUM_REGS-1 times.
REQ-038 Stall and issue have no internal registers; state exists only in the counters and the FSM.

Verification
REQ-039 Reset, then issue add x5 (rd=5) and, the next cycle, present a reader with ra=5, uses_ra=1 -> stall=1 until the cycle after WB of rd=5, then issue=1.
REQ-040 Issue three writers to x7 without WB -> cnt[7]=3; a fourth writer to x7 gives stall=1 (sat_hazard); one WB of x7 -> the fourth issues the next cycle.
REQ-041 Issue to rd=9 and WB of rd=9 in the same cycle, with cnt[9]=1 beforehand -> cnt[9] stays 1 and busy stays 1.
REQ-042 Reader with ra=0 while the x0 "writer" is in flight -> stall=0, busy=0; a WB with idx 0 has no effect.
REQ-043 Set flush=1 with a hazarding instruction in ID -> stall=0, issue=0, counters unchanged.
REQ-044 ebreak issues with x3 pending -> DRAIN and stall=1; WB x3 -> halted=1 on the next cycle; drive rst=0 for one edge -> halted=0, state RUN.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the register hazard scoreboard.
package hazard_scoreboard_pkg;

   localparam int unsigned NUM_REGS_DEF = 32;
   localparam int unsigned CNT_W_DEF    = 2;
   localparam int unsigned IDX_W        = 5;

   // x0 is hardwired zero: never tracked, never a hazard.
   localparam logic [IDX_W-1:0] ZERO_REG = '0;

   typedef enum logic [1:0] {
      SB_RUN,
      SB_DRAIN,
      SB_HALTED
   } sb_state_e;

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One saturating in-flight write counter for a single architectural register.
module sb_entry
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_nonzero,
   output logic o_full
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] r_cnt;

   // Simultaneous inc and dec cancel; dec at zero and inc at max are dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_inc && !i_dec && (r_cnt != CntMax)) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (i_dec && !i_inc && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_nonzero = (r_cnt != '0);
   assign o_full    = (r_cnt == CntMax);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: tracks in-flight writes per register, stalls ID on RAW
// hazards or counter saturation, and drains the pipeline after ebreak.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned NUM_REGS = NUM_REGS_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid_inst,
   input  logic [IDX_W-1:0] id_ra_idx,
   input  logic [IDX_W-1:0] id_rb_idx,
   input  logic             id_uses_ra,
   input  logic             id_uses_rb,
   input  logic             id_reg_wr,
   input  logic [IDX_W-1:0] id_dest_reg_idx,
   input  logic             id_halt,
   input  logic             flush,
   input  logic             wb_valid_inst,
   input  logic             wb_reg_wr,
   input  logic [IDX_W-1:0] wb_dest_reg_idx,
   output logic             stall,
   output logic             issue,
   output logic             busy,
   output logic             halted
);

   sb_state_e           r_state;
   logic [NUM_REGS-1:0] w_nonzero;
   logic [NUM_REGS-1:0] w_full;
   logic                w_inc_en;
   logic                w_dec_en;
   logic                w_src_hazard;
   logic                w_sat_hazard;

   assign w_inc_en = issue & id_reg_wr & (id_dest_reg_idx != ZERO_REG);
   assign w_dec_en = wb_valid_inst & wb_reg_wr & (wb_dest_reg_idx != ZERO_REG);

   // x0 slot is constant so the lookups below never see a hazard on it.
   assign w_nonzero[0] = 1'b0;
   assign w_full[0]    = 1'b0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
      sb_entry #(
         .CNT_W(CNT_W)
      ) u_entry (
         .clk       (clk),
         .rst       (rst),
         .i_inc     (w_inc_en & (id_dest_reg_idx == IDX_W'(g))),
         .i_dec     (w_dec_en & (wb_dest_reg_idx == IDX_W'(g))),
         .o_nonzero (w_nonzero[g]),
         .o_full    (w_full[g])
      );
   end

   // Hazards use registered counts only; a same-cycle writeback does not bypass.
   assign w_src_hazard = (id_uses_ra & w_nonzero[id_ra_idx]) |
                         (id_uses_rb & w_nonzero[id_rb_idx]);
   assign w_sat_hazard = id_reg_wr & w_full[id_dest_reg_idx];

   assign stall  = id_valid_inst & ~flush &
                   (w_src_hazard | w_sat_hazard | (r_state != SB_RUN));
   assign issue  = id_valid_inst & ~flush & ~stall;
   assign busy   = |w_nonzero;
   assign halted = (r_state == SB_HALTED);

   // Halt sequencing: stop issuing on ebreak, halt once all writes retire.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= SB_RUN;
      end else begin
         case (r_state)
            SB_RUN:    if (issue && id_halt) r_state <= SB_DRAIN;
            SB_DRAIN:  if (!busy && !w_dec_en) r_state <= SB_HALTED;
            SB_HALTED: r_state <= SB_HALTED;
            default:   r_state <= SB_RUN;
         endcase
      end
   end

endmodule
